load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte/half/word accesses into word-wide bus transfers.
// Sub-word stores use read-modify-write because the bus has no byte enables.
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [1:0]        lsu_size,
  input  logic              lsu_unsigned,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_ready,
  output logic              lsu_done,
  output logic              lsu_err,
  output logic [31:0]       lsu_rdata,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_wen,
  output logic [31:0]       Bus_wdata,
  input  logic [31:0]       Bus_rdata,
  output logic              Bus_req,
  input  logic              Bus_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state, state_nxt;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       bus_wdata_q, rdata_q;
  logic [CW-1:0]     cnt;

  logic        misaligned, expired;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext, merged;

  assign misaligned = (lsu_size == 2'b11) ||
                      (lsu_size == 2'b01 && lsu_addr[0]) ||
                      (lsu_size == 2'b10 && lsu_addr[1:0] != 2'b00);
  assign expired    = !Bus_ack && (cnt == CNT_LAST);

  assign lsu_ready = (state == IDLE);
  assign lsu_done  = (state == DONE);
  assign lsu_err   = (state == DONE) && err_q;
  assign lsu_rdata = rdata_q;
  assign Bus_req   = (state == RD) || (state == WR);
  assign Bus_wen   = (state == WR);
  assign Bus_addr  = Bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign Bus_wdata = bus_wdata_q;

  // Lane extraction and extension for loads; lane merge for sub-word stores
  always_comb begin
    byte_v   = 8'h00;
    load_ext = Bus_rdata;
    merged   = Bus_rdata;
    case (addr_q[1:0])
      2'b00:   byte_v = Bus_rdata[7:0];
      2'b01:   byte_v = Bus_rdata[15:8];
      2'b10:   byte_v = Bus_rdata[23:16];
      default: byte_v = Bus_rdata[31:24];
    endcase
    half_v = addr_q[1] ? Bus_rdata[31:16] : Bus_rdata[15:0];
    case (size_q)
      2'b00: begin
        load_ext = {{24{!uns_q && byte_v[7]}}, byte_v};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_ext = {{16{!uns_q && half_v[15]}}, half_v};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (lsu_req) begin
        if (misaligned)                         state_nxt = DONE;
        else if (lsu_we && lsu_size == 2'b10)   state_nxt = WR;
        else                                    state_nxt = RD;
      end
      RD: begin
        if (Bus_ack)      state_nxt = we_q ? WR : DONE;
        else if (expired) state_nxt = DONE;
      end
      WR:      if (Bus_ack || expired) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      cnt         <= '0;
    end else begin
      state <= state_nxt;
      // The wait counter restarts whenever a new bus phase begins
      if (state != state_nxt)           cnt <= '0;
      else if (state == RD || state == WR) cnt <= cnt + 1'b1;
      case (state)
        IDLE: if (lsu_req) begin
          we_q    <= lsu_we;
          uns_q   <= lsu_unsigned;
          size_q  <= lsu_size;
          addr_q  <= lsu_addr;
          wdata_q <= lsu_wdata[15:0];
          err_q   <= misaligned;
          if (lsu_we && lsu_size == 2'b10) bus_wdata_q <= lsu_wdata;
        end
        RD: begin
          if (Bus_ack) begin
            if (we_q) bus_wdata_q <= merged;
            else      rdata_q     <= load_ext;
          end else if (expired) begin
            err_q <= 1'b1;
          end
        end
        WR: if (expired) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a simple bus responder plus a scoreboard
// of expected completions (result, error flag, latency from accept).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we, lsu_unsigned;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_ready, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_wen, bus_req, bus_ack;

  logic        ack_en;
  logic [31:0] mem_word;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rd_cnt = 0, wr_cnt = 0, req_cyc = 0, done_cnt = 0;
  logic [31:0] last_bus_addr = '0, last_wr_addr = '0, last_wr_data = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
    int          lat;
    int          accept;
  } exp_t;
  exp_t sb[$];

  load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .cpu_clk(clk), .cpu_rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_ready(lsu_ready), .lsu_done(lsu_done), .lsu_err(lsu_err),
    .lsu_rdata(lsu_rdata),
    .Bus_addr(bus_addr), .Bus_wen(bus_wen), .Bus_wdata(bus_wdata),
    .Bus_rdata(bus_rdata), .Bus_req(bus_req), .Bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  assign bus_ack   = ack_en & bus_req;
  assign bus_rdata = mem_word;

  // Bus observer: running totals, tests look at deltas
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lsu_done) done_cnt <= done_cnt + 1;
    if (bus_req) begin
      req_cyc       <= req_cyc + 1;
      last_bus_addr <= bus_addr;
      if (bus_ack && bus_wen) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= bus_addr;
        last_wr_data <= bus_wdata;
      end else if (bus_ack) begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for one cycle starting at a negedge; returns one cycle later
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic push, input logic [31:0] exp_rdata,
                               input logic chk, input logic exp_err, input int lat);
    exp_t e;
    check("accept_ready", lsu_ready, 1'b1);
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = wdata;
    if (push) begin
      e.rdata = exp_rdata; e.chk_rdata = chk; e.err = exp_err;
      e.lat = lat; e.accept = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    lsu_req = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int waited = 0;
    while (lsu_done !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (lsu_done !== 1'b1) begin
      check({tag, "_done_timeout"}, {31'd0, lsu_done}, 32'd1);
      return;
    end
    check({tag, "_latency"}, cyc - e.accept, e.lat);
    check({tag, "_err"}, lsu_err, e.err);
    check({tag, "_busreq_in_done"}, bus_req, 1'b0);
    if (e.chk_rdata) check({tag, "_rdata"}, lsu_rdata, e.rdata);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, lsu_done, 1'b0);
    check({tag, "_err_low"}, lsu_err, 1'b0);
    check({tag, "_ready_after"}, lsu_ready, 1'b1);
  endtask

  initial begin
    int rd0, wr0, rq0, dn0;
    rst = 1'b1; ack_en = 1'b1; mem_word = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 2'b00; lsu_unsigned = 1'b0;
    lsu_addr = '0; lsu_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", lsu_ready, 1'b1);
    check("rst_done", lsu_done, 1'b0);
    check("rst_err", lsu_err, 1'b0);
    check("rst_rdata", lsu_rdata, 32'h0);
    check("rst_busreq", bus_req, 1'b0);
    check("rst_buswen", bus_wen, 1'b0);
    check("rst_busaddr", bus_addr, 32'h0);
    check("rst_buswdata", bus_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] loads");

    mem_word = 32'h80FF_1234;
    rd0 = rd_cnt; wr0 = wr_cnt;
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 2);
    checkOutput("ldb_signed");
    check("ldb_reads", rd_cnt - rd0, 1);
    check("ldb_writes", wr_cnt - wr0, 0);

    applyStimulus(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b1, 32'h0000_80FF, 1'b1, 1'b0, 2);
    checkOutput("ldh_unsigned");
    check("ldh_busaddr", last_bus_addr, 32'h100);

    applyStimulus(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 1'b1, 32'h0000_0034, 1'b1, 1'b0, 2);
    checkOutput("ldb_unsigned");
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b1, 32'hFFFF_80FF, 1'b1, 1'b0, 2);
    checkOutput("ldh_signed_hi");
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 2);
    checkOutput("ldb_lane2");
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'h80FF_1234, 1'b1, 1'b0, 2);
    checkOutput("ldw");

    $display("[TB] stores");
    mem_word = 32'h1122_3344;
    rd0 = rd_cnt; wr0 = wr_cnt;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00AB, 1'b1, 32'h80FF_1234, 1'b1, 1'b0, 3);
    checkOutput("stb_rmw");
    check("stb_reads", rd_cnt - rd0, 1);
    check("stb_writes", wr_cnt - wr0, 1);
    check("stb_wr_addr", last_wr_addr, 32'h200);
    check("stb_wr_data", last_wr_data, 32'h1122_AB44);

    applyStimulus(1'b1, 2'b01, 1'b0, 32'h202, 32'h5555_BEEF, 1'b1, 32'h80FF_1234, 1'b1, 1'b0, 3);
    checkOutput("sth_rmw");
    check("sth_wr_data", last_wr_data, 32'hBEEF_3344);

    rd0 = rd_cnt;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h300, 32'hDEAD_BEEF, 1'b1, 32'h80FF_1234, 1'b1, 1'b0, 2);
    checkOutput("stw");
    check("stw_reads", rd_cnt - rd0, 0);
    check("stw_wr_addr", last_wr_addr, 32'h300);
    check("stw_wr_data", last_wr_data, 32'hDEAD_BEEF);

    $display("[TB] misaligned and invalid");
    rq0 = req_cyc;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1);
    checkOutput("ldw_misaligned");
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1);
    checkOutput("sth_misaligned");
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1);
    checkOutput("size_invalid");
    check("err_no_bus", req_cyc - rq0, 0);

    $display("[TB] timeout");
    ack_en = 1'b0;
    rq0 = req_cyc; wr0 = wr_cnt;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 5);
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h500;
    @(negedge clk);
    check("timeout_busaddr", bus_addr, 32'h400);
    @(negedge clk);
    lsu_req = 1'b0;
    checkOutput("timeout");
    repeat (3) @(negedge clk);
    check("timeout_req_cycles", req_cyc - rq0, 4);
    check("timeout_no_write", wr_cnt - wr0, 0);
    ack_en = 1'b1;

    $display("[TB] reset during write phase");
    mem_word = 32'h1122_3344;
    dn0 = done_cnt;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00AB, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("rst_mid_wen_before", bus_wen, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wen_after", bus_wen, 1'b0);
    check("rst_mid_req_after", bus_req, 1'b0);
    check("rst_mid_done", lsu_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", lsu_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", done_cnt - dn0, 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
